// File: rtl/warp_register_file.sv
// Per-warp SIMT register file: two registered read ports, one lane-masked
// write port, and a warp-clear sequencer that zeroes one warp at launch.
// Optional macro WRF_BYPASS_EN forwards a same-cycle write (or clear
// zero-write) to a read of the same warp/register.

// One lane's storage slice for every warp/register, with two registered reads.
module wrf_lane #(
  parameter int DEPTH  = 128,
  parameter int IW     = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IW-1:0]     widx,
  input  logic [DATA_W-1:0] wd,
  input  logic              re0,
  input  logic [IW-1:0]     ridx0,
  input  logic              byp0,
  input  logic              re1,
  input  logic [IW-1:0]     ridx1,
  input  logic              byp1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wd;
  end

  // Registered reads; disabled lanes return zero, bypass hits take new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      rd0 <= !re0 ? '0 : (byp0 && we) ? wd : mem[ridx0];
      rd1 <= !re1 ? '0 : (byp1 && we) ? wd : mem[ridx1];
    end
  end
endmodule

module warp_register_file #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_LANES = 16,
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 32,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WW-1:0]               rd_warp,
  input  logic [NUM_LANES-1:0]        read_en_0,
  input  logic [AW-1:0]               raddr_0,
  input  logic [NUM_LANES-1:0]        read_en_1,
  input  logic [AW-1:0]               raddr_1,
  output logic [NUM_LANES*DATA_W-1:0] rdata_0,
  output logic [NUM_LANES*DATA_W-1:0] rdata_1,
  output logic                        rvalid_0,
  output logic                        rvalid_1,
  input  logic [WW-1:0]               wr_warp,
  input  logic [NUM_LANES-1:0]        write_en,
  input  logic [AW-1:0]               waddr,
  input  logic [NUM_LANES*DATA_W-1:0] wdata,
  output logic                        wr_ready,
  input  logic                        clr_req,
  input  logic [WW-1:0]               clr_warp,
  output logic                        clr_busy,
  output logic                        clr_done
);
  localparam int IW = WW + AW;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                              state, state_nxt;
  logic [WW-1:0]                       clr_warp_q;
  logic [AW-1:0]                       clr_cnt;
  logic [NUM_LANES-1:0]                w_mask;
  logic [IW-1:0]                       w_idx;
  logic                                w_zero;
  logic                                byp_0, byp_1;
  logic [NUM_LANES-1:0][DATA_W-1:0]    wd_l, rd0_l, rd1_l;

  // Clear sequencer state, latched target warp and register counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_warp_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && clr_req) begin
        clr_warp_q <= clr_warp;
        clr_cnt    <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Next state and handshake outputs; requests outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b1;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: begin
        wr_ready = 1'b0;
        clr_busy = 1'b1;
        if (clr_cnt == AW'(NUM_REGS - 1)) state_nxt = DONE;
      end
      DONE: begin
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single storage write port shared by the clear sequencer and writeback.
  // Writes are suppressed under reset so an aborted clear stops cleanly.
  always_comb begin
    if (state == CLEAR) begin
      w_mask = '1;
      w_idx  = {clr_warp_q, clr_cnt};
      w_zero = 1'b1;
    end else begin
      w_mask = write_en;
      w_idx  = {wr_warp, waddr};
      w_zero = 1'b0;
    end
    if (rst) w_mask = '0;
  end

  assign wd_l = w_zero ? '0 : wdata;

`ifdef WRF_BYPASS_EN
  assign byp_0 = ({rd_warp, raddr_0} == w_idx);
  assign byp_1 = ({rd_warp, raddr_1} == w_idx);
`else
  assign byp_0 = 1'b0;
  assign byp_1 = 1'b0;
`endif

  // Read valid tracks any enabled lane, one cycle behind the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
    end else begin
      rvalid_0 <= |read_en_0;
      rvalid_1 <= |read_en_1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    wrf_lane #(.DEPTH(NUM_WARPS*NUM_REGS), .IW(IW), .DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (w_mask[i]),
      .widx  (w_idx),
      .wd    (wd_l[i]),
      .re0   (read_en_0[i]),
      .ridx0 ({rd_warp, raddr_0}),
      .byp0  (byp_0),
      .re1   (read_en_1[i]),
      .ridx1 ({rd_warp, raddr_1}),
      .byp1  (byp_1),
      .rd0   (rd0_l[i]),
      .rd1   (rd1_l[i])
    );
  end

  assign rdata_0 = rd0_l;
  assign rdata_1 = rd1_l;
endmodule

// File: tb/tb_warp_register_file.sv
// Directed bench for warp_register_file: reset, masked writes, dual reads,
// full clear with held write, reset mid-clear, same-cycle read/write.
module tb_warp_register_file;
  localparam int NW = 8, NL = 16, NR = 16, DW = 32;
  localparam int WW = 3, AW = 4;
  typedef logic [NL*DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] rd_warp, wr_warp, clr_warp;
  logic [NL-1:0] read_en_0, read_en_1, write_en;
  logic [AW-1:0] raddr_0, raddr_1, waddr;
  vec_t          rdata_0, rdata_1, wdata;
  logic          rvalid_0, rvalid_1, wr_ready, clr_req, clr_busy, clr_done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  warp_register_file #(.NUM_WARPS(NW), .NUM_LANES(NL), .NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .rd_warp(rd_warp), .read_en_0(read_en_0), .raddr_0(raddr_0),
    .read_en_1(read_en_1), .raddr_1(raddr_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .wr_warp(wr_warp), .write_en(write_en), .waddr(waddr), .wdata(wdata),
    .wr_ready(wr_ready), .clr_req(clr_req), .clr_warp(clr_warp),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  function automatic vec_t splat(input logic [DW-1:0] v);
    return {NL{v}};
  endfunction

  // lane i = base + r*256 + i
  function automatic vec_t pat(input logic [DW-1:0] base, input int r);
    vec_t p;
    for (int i = 0; i < NL; i++) p[i*DW +: DW] = base + DW'(r * 256) + DW'(i);
    return p;
  endfunction

  task automatic wr(input int w, input int a, input logic [NL-1:0] en, input vec_t d);
    wr_warp = WW'(w); waddr = AW'(a); write_en = en; wdata = d;
    tick;
    write_en = '0;
  endtask

  task automatic rd0(input int w, input int a);
    rd_warp = WW'(w); raddr_0 = AW'(a); read_en_0 = '1;
    tick;
    read_en_0 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rd_warp = '0; wr_warp = '0; clr_warp = '0;
    read_en_0 = '1; read_en_1 = '0; raddr_0 = '0; raddr_1 = '0;
    write_en = '0; waddr = '0; wdata = '0; clr_req = 1'b0;

    // Reset state
    tick; tick;
    chk ("rst_rdata0", rdata_0, '0);
    chk1("rst_rvalid0", rvalid_0, 1'b0);
    chk1("rst_busy", clr_busy, 1'b0);
    chk1("rst_done", clr_done, 1'b0);
    chk1("rst_wr_ready", wr_ready, 1'b1);
    rst = 1'b0; read_en_0 = '0;

    // Full write, dual-port read, warp isolation
    wr(3, 5, '1, pat(32'hA500_0000, 0));
    rd_warp = 3'd3; raddr_0 = 4'd5; raddr_1 = 4'd5; read_en_0 = '1; read_en_1 = '1;
    tick;
    read_en_0 = '0; read_en_1 = '0;
    chk ("w3r5_p0", rdata_0, pat(32'hA500_0000, 0));
    chk ("w3r5_p1", rdata_1, pat(32'hA500_0000, 0));
    chk1("rvalid0", rvalid_0, 1'b1);
    chk1("rvalid1", rvalid_1, 1'b1);
    tick;
    chk1("rvalid0_off", rvalid_0, 1'b0);
    chk ("rdata0_off", rdata_0, '0);
    wr(2, 5, '1, splat(32'h5555_5555));
    rd0(2, 5);
    chk ("w2r5_isolated", rdata_0, splat(32'h5555_5555));

    // Lane-masked write and lane-masked read
    wr(0, 1, '1, splat(32'h1111_1111));
    wr(0, 1, 16'h00FF, splat(32'h2222_2222));
    rd0(0, 1);
    chk ("mask_write", rdata_0, {{8{32'h1111_1111}}, {8{32'h2222_2222}}});
    rd_warp = 3'd0; raddr_0 = 4'd1; read_en_0 = 16'h000F;
    tick;
    read_en_0 = '0;
    chk ("mask_read", rdata_0, {{12{32'h0}}, {4{32'h2222_2222}}});

    // Clear of warp 7 with a write held off by wr_ready
    for (int r = 0; r < NR; r++) wr(7, r, '1, pat(32'h7000_0000, r));
    wr(6, 0, '1, splat(32'h6666_6666));
    wr(5, 2, '1, splat(32'hAAAA_AAAA));
    rd_warp = 3'd5; raddr_0 = 4'd2; read_en_0 = '1;
    clr_req = 1'b1; clr_warp = 3'd7;
    tick;
    clr_req = 1'b0;
    wr_warp = 3'd5; waddr = 4'd2; write_en = '1; wdata = splat(32'hBBBB_BBBB);
    for (int k = 0; k < NR; k++) begin
      chk1("clr_busy", clr_busy, 1'b1);
      chk1("clr_wr_ready", wr_ready, 1'b0);
      chk1("clr_done_early", clr_done, 1'b0);
      chk ("held_write", rdata_0, splat(32'hAAAA_AAAA));
      clr_req = (k == 3);
      clr_warp = 3'd6;
      tick;
    end
    clr_req = 1'b0;
    chk1("done_pulse", clr_done, 1'b1);
    chk1("done_busy", clr_busy, 1'b0);
    chk1("done_wr_ready", wr_ready, 1'b1);
    tick;
    write_en = '0; read_en_0 = '0;
    chk1("done_once", clr_done, 1'b0);
    tick; tick;
    chk1("ignored_req", clr_busy, 1'b0);
    rd0(5, 2);
    chk ("held_write_applied", rdata_0, splat(32'hBBBB_BBBB));
    for (int r = 0; r < NR; r++) begin
      rd0(7, r);
      chk ("w7_cleared", rdata_0, '0);
    end
    rd0(6, 0);
    chk ("w6_kept", rdata_0, splat(32'h6666_6666));

    // Reset in the 5th cycle of a clear of warp 1
    for (int r = 0; r < NR; r++) wr(1, r, '1, pat(32'h1000_0000, r));
    clr_req = 1'b1; clr_warp = 3'd1;
    tick;
    clr_req = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk1("abort_busy", clr_busy, 1'b0);
    chk1("abort_wr_ready", wr_ready, 1'b1);
    chk1("abort_rvalid", rvalid_0, 1'b0);
    tick;
    chk1("abort_idle", clr_busy, 1'b0);
    chk1("abort_no_done", clr_done, 1'b0);
    for (int r = 0; r < NR; r++) begin
      rd0(1, r);
      chk ("partial_clear", rdata_0, (r < 4) ? '0 : pat(32'h1000_0000, r));
    end

    // Same-cycle write and read of warp 4 reg 9
    wr(4, 9, '1, '0);
    wr_warp = 3'd4; waddr = 4'd9; write_en = '1; wdata = splat(32'hDEAD_BEEF);
    rd_warp = 3'd4; raddr_0 = 4'd9; read_en_0 = '1;
    tick;
    write_en = '0; read_en_0 = '0;
`ifdef WRF_BYPASS_EN
    chk ("same_cycle", rdata_0, splat(32'hDEAD_BEEF));
`else
    chk ("same_cycle", rdata_0, '0);
`endif
    rd0(4, 9);
    chk ("after_write", rdata_0, splat(32'hDEAD_BEEF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
